// File: rtl/generador_sensores_if.sv
// Request/sensor bundle between a requester and the generador_sensores emulator.
// GEN_SENSORES_ABORT_EN adds the abort request line.
interface generador_sensores_if;
    logic       req_entra;
    logic       req_sale;
    logic       req_persona;
`ifdef GEN_SENSORES_ABORT_EN
    logic       abort;
`endif
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic [1:0] tipo;

`ifdef GEN_SENSORES_ABORT_EN
    modport master (
        output req_entra, req_sale, req_persona, abort,
        input  a, b, busy, done, tipo
    );
    modport slave (
        input  req_entra, req_sale, req_persona, abort,
        output a, b, busy, done, tipo
    );
`else
    modport master (
        output req_entra, req_sale, req_persona,
        input  a, b, busy, done, tipo
    );
    modport slave (
        input  req_entra, req_sale, req_persona,
        output a, b, busy, done, tipo
    );
`endif
endinterface

// File: rtl/generador_sensores.sv
// Emulates the A/B parking sensor pair: entry, exit or pedestrian pattern on request.
// Optional GEN_SENSORES_ABORT_EN adds an abort input that jumps straight to the idle gap.
module generador_sensores #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned CNT_W       = 8
) (
    input logic                clk,
    input logic                reset,
    generador_sensores_if.slave bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PH1  = 3'd1;
    localparam logic [2:0] ST_PH2  = 3'd2;
    localparam logic [2:0] ST_PH3  = 3'd3;
    localparam logic [2:0] ST_GAP  = 3'd4;

    localparam logic [1:0] T_NONE    = 2'b00;
    localparam logic [1:0] T_ENTRA   = 2'b01;
    localparam logic [1:0] T_SALE    = 2'b10;
    localparam logic [1:0] T_PERSONA = 2'b11;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       tipo_q, tipo_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             abort_req;

`ifdef GEN_SENSORES_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tipo_d  = tipo_q;
        done_d  = 1'b0;

        if (state_q == ST_IDLE) begin
            if (bus.req_entra) begin
                tipo_d  = T_ENTRA;
                state_d = ST_PH1;
                cnt_d   = '0;
            end else if (bus.req_sale) begin
                tipo_d  = T_SALE;
                state_d = ST_PH1;
                cnt_d   = '0;
            end else if (bus.req_persona) begin
                tipo_d  = T_PERSONA;
                state_d = ST_PH1;
                cnt_d   = '0;
            end
        end else if (abort_req) begin
            // Abort beats phase advance; re-entering GAP restarts its count.
            state_d = ST_GAP;
            cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (state_q)
                ST_PH1:  state_d = (tipo_q == T_PERSONA) ? ST_GAP : ST_PH2;
                ST_PH2:  state_d = ST_PH3;
                ST_PH3:  state_d = ST_GAP;
                ST_GAP: begin
                    state_d = ST_IDLE;
                    tipo_d  = T_NONE;
                    done_d  = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            cnt_d = cnt_q + 1'b1;
        end

        busy_d = (state_d != ST_IDLE);

        // Outputs are decoded from the next state so they land in flops on the same edge.
        a_d = 1'b0;
        b_d = 1'b0;
        case (state_d)
            ST_PH1: begin
                a_d = (tipo_d != T_SALE);
                b_d = (tipo_d == T_SALE);
            end
            ST_PH2: begin
                a_d = 1'b1;
                b_d = 1'b1;
            end
            ST_PH3: begin
                a_d = (tipo_d == T_SALE);
                b_d = (tipo_d == T_ENTRA);
            end
            default: begin
                a_d = 1'b0;
                b_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            tipo_q  <= T_NONE;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tipo_q  <= tipo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.a    = a_q;
    assign bus.b    = b_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.tipo = tipo_q;
endmodule

// File: tb/tb_generador_sensores.sv
// Drives two generators (HOLD_CYCLES 4 and 1) with shared stimulus and scores each against
// a cycle-plan reference model. GEN_SENSORES_ABORT_EN enables the abort scenarios.
module tb_generador_sensores;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_e = 1'b0;
    logic req_s = 1'b0;
    logic req_p = 1'b0;
    logic abort_s = 1'b0;
    int   n_total = 0;
    int   n_pass  = 0;

    always #5 clk = ~clk;

    // Expected sample packing: {a, b, busy, done, tipo}
    localparam logic [5:0] IDLE_EXP = 6'b000000;

    function automatic logic [1:0] phase_ab(input logic [1:0] t, input int p);
        logic [1:0] r;
        r = 2'b00;
        case (t)
            2'b01: r = (p == 0) ? 2'b10 : (p == 1) ? 2'b11 : 2'b01;
            2'b10: r = (p == 0) ? 2'b01 : (p == 1) ? 2'b11 : 2'b10;
            2'b11: r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : inst
        localparam int unsigned H = (g == 0) ? 4 : 1;

        generador_sensores_if sif ();
        assign sif.req_entra   = req_e;
        assign sif.req_sale    = req_s;
        assign sif.req_persona = req_p;
`ifdef GEN_SENSORES_ABORT_EN
        assign sif.abort = abort_s;
`endif

        generador_sensores #(.HOLD_CYCLES(H), .CNT_W(8)) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (sif)
        );

        logic [5:0] plan[$];
        logic [5:0] expq[$];
        logic [1:0] cur_t;

        task automatic push_gap();
            for (int k = 0; k < int'(H); k++) plan.push_back({2'b00, 1'b1, 1'b0, cur_t});
            plan.push_back({2'b00, 1'b0, 1'b1, 2'b00});
        endtask

        // Reference: the generator is busy exactly while it still has planned cycles.
        always @(posedge clk) begin
            logic [1:0] t;
            if (rst) begin
                plan.delete();
            end else begin
                if (plan.size() != 0) begin
`ifdef GEN_SENSORES_ABORT_EN
                    if (abort_s) begin
                        plan.delete();
                        push_gap();
                    end
`endif
                end else begin
                    t = req_e ? 2'b01 : req_s ? 2'b10 : req_p ? 2'b11 : 2'b00;
                    if (t != 2'b00) begin
                        cur_t = t;
                        for (int p = 0; p < ((t == 2'b11) ? 1 : 3); p++)
                            for (int k = 0; k < int'(H); k++)
                                plan.push_back({phase_ab(t, p), 1'b1, 1'b0, t});
                        push_gap();
                    end
                end
                expq.push_back((plan.size() != 0) ? plan.pop_front() : IDLE_EXP);
            end
        end

        // Monitor: compares the DUT's registered outputs mid-cycle.
        always @(negedge clk) begin
            logic [5:0] act;
            logic [5:0] exp;
            act = {sif.a, sif.b, sif.busy, sif.done, sif.tipo};
            if (rst) begin
                expq.delete();
                n_total++;
                if (act == IDLE_EXP) n_pass++;
                else $display("FAIL reset_h%0d t=%0t: a,b,busy,done,tipo got %b need %b",
                              H, $time, act, IDLE_EXP);
            end else if (expq.size() != 0) begin
                exp = expq.pop_front();
                n_total++;
                if (act == exp) n_pass++;
                else $display("FAIL seq_h%0d t=%0t: a,b,busy,done,tipo got %b need %b",
                              H, $time, act, exp);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input logic e, input logic s, input logic p);
        req_e = e;
        req_s = s;
        req_p = p;
        step(1);
        req_e = 1'b0;
        req_s = 1'b0;
        req_p = 1'b0;
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        step(2);

        pulse(1'b1, 1'b0, 1'b0);          // entry
        step(20);
        pulse(1'b0, 1'b1, 1'b0);          // exit
        step(20);
        pulse(1'b1, 1'b1, 1'b1);          // priority: entry wins
        step(4);
        pulse(1'b0, 1'b1, 1'b0);          // ignored while busy
        step(20);
        pulse(1'b0, 1'b0, 1'b1);          // pedestrian
        step(12);

        pulse(1'b1, 1'b0, 1'b0);          // reset during PH2 of entry
        step(5);
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);

        req_p = 1'b1;                     // held request restarts after each done
        step(30);
        req_p = 1'b0;
        step(10);

`ifdef GEN_SENSORES_ABORT_EN
        pulse(1'b1, 1'b0, 1'b0);
        step(5);
        abort_s = 1'b1;
        step(1);
        abort_s = 1'b0;
        step(12);
        abort_s = 1'b1;                   // abort in idle: no effect
        step(2);
        abort_s = 1'b0;
        step(2);
`endif

        for (int i = 0; i < 800; i++) begin
            req_e = ($urandom_range(0, 9) == 0);
            req_s = ($urandom_range(0, 9) == 0);
            req_p = ($urandom_range(0, 9) == 0);
`ifdef GEN_SENSORES_ABORT_EN
            abort_s = ($urandom_range(0, 24) == 0);
`endif
            if ($urandom_range(0, 149) == 0) begin
                rst = 1'b1;
                step(1);
                rst = 1'b0;
            end else begin
                step(1);
            end
        end
        req_e = 1'b0;
        req_s = 1'b0;
        req_p = 1'b0;
        abort_s = 1'b0;
        step(20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
